// File: rtl/dac_interp_feed_pkg.sv
// Shared constants and helpers for the delta-sigma DAC sample feeder.
package dac_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  // Two's complement to offset binary: flip the sign bit.
  function automatic logic [SAMPLE_W-1:0] to_offset_bin(input logic signed [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/dac_interp_feed_if.sv
// Sample input handshake plus DAC-side outputs of the feeder.
interface dac_interp_feed_if;

  logic signed [dac_pkg::SAMPLE_W-1:0] in_data;
  logic                                in_valid;
  logic                                in_ready;
  logic        [dac_pkg::SAMPLE_W-1:0] DACout;
  logic                                sample_tick;
  logic                                underrun;

  modport master (
    output in_data, in_valid,
    input  in_ready, DACout, sample_tick, underrun
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, DACout, sample_tick, underrun
  );

endinterface

// File: rtl/dac_interp_feed_fifo.sv
// Small synchronous FIFO buffering samples between the audio-rate source and the DAC feed.
module dac_sample_fifo #(
  parameter int unsigned W          = 16,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [W-1:0]          mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign full    = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign dout    = mem[rd_ptr_q];
  // No bypass: a full FIFO refuses a push even while it pops.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/dac_interp_feed.sv
// Feeds the 1-bit delta-sigma DAC: buffers samples, pulls one per oversampling period and
// drives offset-binary output every Clk. Define DAC_INTERP_EN for linear interpolation;
// otherwise the output is a zero-order hold of the current sample.
module dac_interp_feed
  import dac_pkg::*;
#(
  parameter int unsigned OSR_LOG2   = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input logic             Clk,
  input logic             Rst,
  dac_interp_feed_if.slave bus
);

  logic [OSR_LOG2-1:0]        phase_q, phase_d;
  logic                       tick_q, tick_d;
  logic signed [SAMPLE_W-1:0] prev_q, prev_d, cur_q, cur_d, y;
  logic [SAMPLE_W-1:0]        dac_q, head;
  logic                       fifo_full, fifo_empty, pop;

  // Sample is consumed only on a tick; a same-cycle push into an empty FIFO waits.
  assign pop = tick_q & ~fifo_empty;

  dac_sample_fifo #(
    .W          (SAMPLE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (bus.in_valid),
    .din   (bus.in_data),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty)
  );

`ifdef DAC_INTERP_EN
  localparam int unsigned AccW = SAMPLE_W + 1 + OSR_LOG2;

  logic signed [SAMPLE_W:0] delta;
  logic signed [AccW-1:0]   acc_q, acc_d;

  // Ramp accumulator: acc = delta * phase, cleared at each tick.
  always_comb begin
    delta = signed'({cur_q[SAMPLE_W-1], cur_q}) - signed'({prev_q[SAMPLE_W-1], prev_q});
    acc_d = tick_q ? '0 : acc_q + AccW'(delta);
    // Result lies between prev and cur, so truncating the scaled step cannot wrap.
    y     = prev_d + SAMPLE_W'(acc_d >>> OSR_LOG2);
  end

  // Accumulator register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`else
  // Zero-order hold: output follows the current sample directly.
  always_comb begin
    y = cur_d;
  end
`endif

  // Phase counter next state; tick is registered so it is high while phase is N-1.
  always_comb begin
    phase_d = phase_q + OSR_LOG2'(1);
    tick_d  = &phase_d;
    prev_d  = tick_q ? cur_q : prev_q;
    cur_d   = pop ? signed'(head) : cur_q;
  end

  // Phase, sample history and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      phase_q <= '0;
      tick_q  <= 1'b0;
      prev_q  <= '0;
      cur_q   <= '0;
      dac_q   <= MIDSCALE;
    end else begin
      phase_q <= phase_d;
      tick_q  <= tick_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      dac_q   <= to_offset_bin(y);
    end
  end

  assign bus.in_ready    = ~fifo_full;
  assign bus.DACout      = dac_q;
  assign bus.sample_tick = tick_q;
  assign bus.underrun    = tick_q & fifo_empty;

endmodule

// File: tb/tb_dac_interp_feed.sv
// Directed bench for dac_interp_feed with a 4-cycle sample period and 4-entry FIFO.
module tb_dac_interp_feed;

  typedef struct packed {
    logic [15:0] dac;
    logic        tick;
    logic        und;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  dac_interp_feed_if bus ();

  dac_interp_feed #(
    .OSR_LOG2   (2),
    .DEPTH_LOG2 (2)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected sequence to end");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic add_period(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                            input logic [15:0] d3, input logic und);
    exp_q.push_back({d0, 1'b0, 1'b0});
    exp_q.push_back({d1, 1'b0, 1'b0});
    exp_q.push_back({d2, 1'b0, 1'b0});
    exp_q.push_back({d3, 1'b1, und});
  endtask

  // One clock, then compare outputs against the next expected entry.
  task automatic cyc(input string tag);
    exp_t e;
    step();
    if (exp_q.size() == 0) begin
      chk({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " DACout"}, 32'(bus.DACout), 32'(e.dac));
      chk({tag, " tick"}, 32'(bus.sample_tick), 32'(e.tick));
      chk({tag, " underrun"}, 32'(bus.underrun), 32'(e.und));
    end
  endtask

  initial begin
    // Phases 1..3 right after reset release: empty FIFO, underrun at the first tick.
    exp_q.push_back({16'h8000, 1'b0, 1'b0});
    exp_q.push_back({16'h8000, 1'b0, 1'b0});
    exp_q.push_back({16'h8000, 1'b1, 1'b1});
    add_period(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);   // P0: filling
`ifdef DAC_INTERP_EN
    add_period(16'h8000, 16'h8100, 16'h8200, 16'h8300, 1'b0);   // 0 -> 0x0400
    add_period(16'h8400, 16'h9300, 16'hA200, 16'hB100, 1'b0);   // 0x0400 -> 0x4000
    add_period(16'hC000, 16'h9000, 16'h6000, 16'h3000, 1'b0);   // 0x4000 -> -32768
    add_period(16'h0000, 16'h3FFF, 16'h7FFF, 16'hBFFF, 1'b0);   // full-scale rise
    add_period(16'hFFFF, 16'hDFFF, 16'hBFFF, 16'h9FFF, 1'b0);   // 32767 -> 0, floor
    add_period(16'h8000, 16'h848D, 16'h891A, 16'h8DA7, 1'b1);   // 0 -> 0x1234, then empty
    add_period(16'h9234, 16'h9234, 16'h9234, 16'h9234, 1'b1);   // hold, still empty
    add_period(16'h9234, 16'h9234, 16'h9234, 16'h9234, 1'b0);   // hold, G waiting
    exp_q.push_back({16'h9234, 1'b0, 1'b0});
    exp_q.push_back({16'h9DA7, 1'b0, 1'b0});
`else
    add_period(16'h8400, 16'h8400, 16'h8400, 16'h8400, 1'b0);
    add_period(16'hC000, 16'hC000, 16'hC000, 16'hC000, 1'b0);
    add_period(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    add_period(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    add_period(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
    add_period(16'h9234, 16'h9234, 16'h9234, 16'h9234, 1'b1);
    add_period(16'h9234, 16'h9234, 16'h9234, 16'h9234, 1'b1);
    add_period(16'h9234, 16'h9234, 16'h9234, 16'h9234, 1'b0);
    exp_q.push_back({16'hC000, 1'b0, 1'b0});
    exp_q.push_back({16'hC000, 1'b0, 1'b0});
`endif

    Rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    step();
    step();
    chk("reset DACout", 32'(bus.DACout), 32'h8000);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset tick", 32'(bus.sample_tick), 32'd0);
    chk("reset underrun", 32'(bus.underrun), 32'd0);
    Rst = 1'b0;

    cyc("z1");
    cyc("z2");
    cyc("z3");

    // Fill: A,B,C,D pushed across a tick (which pops A), E fills it, F must wait.
    cyc("p0_0");
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0400;
    cyc("p0_1");
    bus.in_data  = 16'h4000;
    cyc("p0_2");
    bus.in_data  = 16'h8000;
    cyc("p0_3");
    chk("ready p0_3", 32'(bus.in_ready), 32'd1);
    bus.in_data  = 16'h7FFF;
    cyc("p1_0");
    chk("ready p1_0", 32'(bus.in_ready), 32'd1);
    bus.in_data  = 16'h0000;
    cyc("p1_1");
    chk("ready full p1_1", 32'(bus.in_ready), 32'd0);
    bus.in_data  = 16'h1234;
    cyc("p1_2");
    chk("ready full p1_2", 32'(bus.in_ready), 32'd0);
    cyc("p1_3");
    chk("ready full at pop", 32'(bus.in_ready), 32'd0);
    cyc("p2_0");
    chk("ready after pop", 32'(bus.in_ready), 32'd1);
    cyc("p2_1");
    chk("ready refilled", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 22; i++) cyc($sformatf("run%0d", i));

    // Push into an empty FIFO on the tick edge, then refill.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4000;
    cyc("p8_0");
    bus.in_data  = 16'h1111;
    cyc("p8_1");
    cyc("p8_2");
    cyc("p8_3");
    chk("ready p8_3", 32'(bus.in_ready), 32'd0);
    cyc("p9_0");
    chk("ready p9_0", 32'(bus.in_ready), 32'd1);
    cyc("p9_1");
    chk("ready p9_1", 32'(bus.in_ready), 32'd0);

    // Asynchronous reset mid-ramp.
    #2;
    Rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("async rst DACout", 32'(bus.DACout), 32'h8000);
    chk("async rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("async rst underrun", 32'(bus.underrun), 32'd0);
    chk("async rst tick", 32'(bus.sample_tick), 32'd0);
    step();
    Rst = 1'b0;
    step();
    chk("restart ph1 tick", 32'(bus.sample_tick), 32'd0);
    step();
    chk("restart ph2 tick", 32'(bus.sample_tick), 32'd0);
    step();
    chk("restart ph3 tick", 32'(bus.sample_tick), 32'd1);
    chk("restart ph3 underrun", 32'(bus.underrun), 32'd1);
    chk("restart DACout", 32'(bus.DACout), 32'h8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
